// File: rtl/lv_efuse_if.sv
// Efuse load sequencer bus: control FSM handshake,
// analog efuse macro read port and shadow register write port.
interface lv_efuse_if #(
  parameter int EFUSE_ADDR_W = 3,
  parameter int EFUSE_DATA_W = 8
);
  logic                    i_pwr_on;
  logic                    i_efuse_load_req;
  logic                    o_efuse_load_done;
  logic                    o_efuse_vld;
  logic                    o_efuse_crc_err;
  logic                    o_efuse_busy;
  logic                    o_efuse_csb;
  logic                    o_efuse_rden;
  logic [EFUSE_ADDR_W-1:0] o_efuse_addr;
  logic [EFUSE_DATA_W-1:0] i_efuse_rdata;
  logic                    o_efuse_wr_en;
  logic [EFUSE_ADDR_W-1:0] o_efuse_wr_addr;
  logic [EFUSE_DATA_W-1:0] o_efuse_wr_data;

  modport master (
    input  i_pwr_on,
    input  i_efuse_load_req,
    input  i_efuse_rdata,
    output o_efuse_load_done,
    output o_efuse_vld,
    output o_efuse_crc_err,
    output o_efuse_busy,
    output o_efuse_csb,
    output o_efuse_rden,
    output o_efuse_addr,
    output o_efuse_wr_en,
    output o_efuse_wr_addr,
    output o_efuse_wr_data
  );

  modport slave (
    output i_pwr_on,
    output i_efuse_load_req,
    output i_efuse_rdata,
    input  o_efuse_load_done,
    input  o_efuse_vld,
    input  o_efuse_crc_err,
    input  o_efuse_busy,
    input  o_efuse_csb,
    input  o_efuse_rden,
    input  o_efuse_addr,
    input  o_efuse_wr_en,
    input  o_efuse_wr_addr,
    input  o_efuse_wr_data
  );
endinterface

// File: rtl/lv_efuse_load_ctrl.sv
// Efuse load sequencer: timed word reads into the shadow
// register file with trailing XOR checksum verification.
module lv_efuse_load_ctrl #(
  parameter int EFUSE_WORD_NUM = 8,
  parameter int EFUSE_ADDR_W   = 3,
  parameter int EFUSE_DATA_W   = 8,
  parameter int RD_SETUP_CYC   = 4,
  parameter int RD_PULSE_CYC   = 8,
  parameter int RD_HOLD_CYC    = 2,
  parameter int CYC_CNT_W      = 4
) (
  input logic        i_clk,
  input logic        i_rst_n,
  lv_efuse_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, CHECK, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CYC_CNT_W-1:0]    cnt_q;
  logic [EFUSE_ADDR_W-1:0] idx_q;
  logic [EFUSE_DATA_W-1:0] acc_q;
  logic                    nz_q;
  logic                    req_d;

  logic start, abort, ph_end, last_word;

  logic                    done_q, done_d;
  logic                    vld_q, vld_d;
  logic                    crc_q, crc_d;
  logic                    busy_q, busy_d;
  logic                    csb_q, csb_d;
  logic                    rden_q, rden_d;
  logic [EFUSE_ADDR_W-1:0] addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [EFUSE_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [EFUSE_DATA_W-1:0] wr_data_q, wr_data_d;

  assign start = bus.i_efuse_load_req
               & ~req_d & bus.i_pwr_on;
  assign abort = (state_q != IDLE)
               & (~bus.i_pwr_on | ~bus.i_efuse_load_req);
  assign last_word =
    idx_q == EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  always_comb begin
    ph_end = 1'b1;
    unique case (state_q)
      SETUP: ph_end =
        cnt_q == CYC_CNT_W'(RD_SETUP_CYC - 1);
      PULSE: ph_end =
        cnt_q == CYC_CNT_W'(RD_PULSE_CYC - 1);
      HOLD: ph_end =
        cnt_q == CYC_CNT_W'(RD_HOLD_CYC - 1);
      default: ph_end = 1'b1;
    endcase
  end

  // State register, phase counter and checksum datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      nz_q    <= 1'b0;
      req_d   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_d   <= bus.i_efuse_load_req;
      if (state_d != state_q || state_q == IDLE)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE && start) begin
        idx_q <= '0;
        acc_q <= '0;
        nz_q  <= 1'b0;
      end
      if (state_q == PULSE && ph_end && !abort) begin
        acc_q <= acc_q ^ bus.i_efuse_rdata;
        if (!last_word)
          nz_q <= nz_q | (|bus.i_efuse_rdata);
      end
      if (state_q == HOLD && ph_end && !abort
          && !last_word)
        idx_q <= idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (start) state_d = SETUP;
        SETUP: if (ph_end) state_d = PULSE;
        PULSE: if (ph_end) state_d = HOLD;
        HOLD:  if (ph_end)
                 state_d = last_word ? CHECK : SETUP;
        CHECK: state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    vld_d     = vld_q;
    crc_d     = crc_q;
    csb_d     = csb_q;
    rden_d    = rden_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = state_d != IDLE;
    if (abort) begin
      csb_d  = 1'b1;
      rden_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          csb_d  = 1'b0;
          addr_d = '0;
          vld_d  = 1'b0;
          crc_d  = 1'b0;
        end
        SETUP: if (ph_end) rden_d = 1'b1;
        PULSE: if (ph_end) begin
          rden_d    = 1'b0;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = bus.i_efuse_rdata;
        end
        HOLD: if (ph_end) begin
          if (last_word) csb_d = 1'b1;
          else addr_d = addr_q + 1'b1;
        end
        // Blank array: zero XOR but no data bit set
        CHECK: begin
          done_d = 1'b1;
          vld_d  = (acc_q == '0) && nz_q;
          crc_d  = acc_q != '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      crc_q     <= 1'b0;
      busy_q    <= 1'b0;
      csb_q     <= 1'b1;
      rden_q    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      done_q    <= done_d;
      vld_q     <= vld_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      csb_q     <= csb_d;
      rden_q    <= rden_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.o_efuse_load_done = done_q;
  assign bus.o_efuse_vld       = vld_q;
  assign bus.o_efuse_crc_err   = crc_q;
  assign bus.o_efuse_busy      = busy_q;
  assign bus.o_efuse_csb       = csb_q;
  assign bus.o_efuse_rden      = rden_q;
  assign bus.o_efuse_addr      = addr_q;
  assign bus.o_efuse_wr_en     = wr_en_q;
  assign bus.o_efuse_wr_addr   = wr_addr_q;
  assign bus.o_efuse_wr_data   = wr_data_q;

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// Self-checking bench for lv_efuse_load_ctrl: vector table,
// random words vs. checksum model, strobe timing, aborts.
module tb_lv_efuse_load_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lv_efuse_if #(
    .EFUSE_ADDR_W(3),
    .EFUSE_DATA_W(8)
  ) bif ();

  lv_efuse_load_ctrl dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif)
  );

  logic [7:0] mem [8];
  assign bif.i_efuse_rdata =
    bif.o_efuse_rden ? mem[bif.o_efuse_addr] : 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // Checksum rules: XOR of all words must be zero and some
  // data word (not the checksum) must be non-zero.
  function automatic logic [1:0] ref_model(
    input logic [63:0] w);
    logic [7:0] x;
    logic nz;
    x = 8'h00;
    nz = 1'b0;
    for (int i = 0; i < 8; i++) x ^= w[8*i +: 8];
    for (int i = 0; i < 7; i++)
      if (w[8*i +: 8] != 8'h00) nz = 1'b1;
    return {(x == 8'h00) && nz, x != 8'h00};
  endfunction

  logic [15:0] wq [$];
  bit mon_on = 1'b0;
  logic rden_p = 1'b0;
  logic rise, fall;
  int su = 0;
  int pl = 0;
  int post = 0;
  logic [2:0] a_lat = 3'd0;

  always @(negedge clk) begin
    if (bif.o_efuse_wr_en)
      wq.push_back({5'b0, bif.o_efuse_wr_addr,
                    bif.o_efuse_wr_data});
    rise = bif.o_efuse_rden && !rden_p;
    fall = !bif.o_efuse_rden && rden_p;
    if (rise) a_lat = bif.o_efuse_addr;
    if (fall) post = 2;
    if (mon_on) begin
      if (rise) check("setup_len", 32'(su >= 4), 1);
      if (fall) check("pulse_len", pl, 8);
      if (bif.o_efuse_rden || post > 0)
        check("addr_stable", 32'(bif.o_efuse_addr),
              32'(a_lat));
    end
    if (post > 0 && !bif.o_efuse_rden) post--;
    if (rise) pl = 1;
    else if (bif.o_efuse_rden) pl++;
    if (!bif.o_efuse_csb && !bif.o_efuse_rden) su++;
    else su = 0;
    rden_p = bif.o_efuse_rden;
  end

  task automatic run_load(input string nm,
                          input logic [63:0] w,
                          input logic ev,
                          input logic ec,
                          input bit keep);
    int done_c;
    int done_n;
    logic v_at, c_at, busy_after;
    for (int i = 0; i < 8; i++) mem[i] = w[8*i +: 8];
    @(negedge clk);
    wq.delete();
    mon_on = 1'b1;
    bif.i_efuse_load_req = 1'b1;
    done_c = -1;
    done_n = 0;
    v_at = 1'b0;
    c_at = 1'b0;
    busy_after = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (bif.o_efuse_load_done) begin
        done_n++;
        if (done_c < 0) begin
          done_c = c;
          v_at = bif.o_efuse_vld;
          c_at = bif.o_efuse_crc_err;
        end
      end
      if (done_c > 0 && c == done_c + 1)
        busy_after = bif.o_efuse_busy;
    end
    check({nm, "_done_cnt"}, done_n, 1);
    check({nm, "_done_cyc"}, done_c, 114);
    check({nm, "_vld"}, 32'(v_at), 32'(ev));
    check({nm, "_crc"}, 32'(c_at), 32'(ec));
    check({nm, "_busy_after"}, 32'(busy_after), 0);
    check({nm, "_vld_level"}, 32'(bif.o_efuse_vld),
          32'(ev));
    check({nm, "_wr_cnt"}, wq.size(), 8);
    for (int i = 0; i < 8; i++)
      check({nm, "_wr"},
            i < wq.size() ? 32'(wq[i]) : 32'hdead,
            32'({5'b0, 3'(i), w[8*i +: 8]}));
    if (!keep) bif.i_efuse_load_req = 1'b0;
  endtask

  typedef struct packed {
    logic [63:0] w;
    logic        vld;
    logic        crc;
  } vec_t;

  vec_t tbl [6];
  logic [63:0] r;
  logic [7:0] x;
  logic [1:0] m;
  bit found;
  int cnt_done, cnt_busy;

  initial begin
    tbl[0] = '{w: 64'h00_77_66_55_44_33_22_11,
               vld: 1'b1, crc: 1'b0};
    tbl[1] = '{w: 64'h01_77_66_55_44_33_22_11,
               vld: 1'b0, crc: 1'b1};
    tbl[2] = '{w: 64'h0, vld: 1'b0, crc: 1'b0};
    r = {$urandom, $urandom};
    m = ref_model(r);
    tbl[3] = '{w: r, vld: m[1], crc: m[0]};
    r = {$urandom, $urandom};
    x = 8'h00;
    for (int i = 0; i < 7; i++) x ^= r[8*i +: 8];
    r[63:56] = x;
    m = ref_model(r);
    tbl[4] = '{w: r, vld: m[1], crc: m[0]};
    r = 64'h0;
    r[63:56] = 8'($urandom_range(1, 255));
    m = ref_model(r);
    tbl[5] = '{w: r, vld: m[1], crc: m[0]};

    bif.i_pwr_on = 1'b1;
    bif.i_efuse_load_req = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_done", 32'(bif.o_efuse_load_done), 0);
    check("rst_vld", 32'(bif.o_efuse_vld), 0);
    check("rst_crc", 32'(bif.o_efuse_crc_err), 0);
    check("rst_busy", 32'(bif.o_efuse_busy), 0);
    check("rst_csb", 32'(bif.o_efuse_csb), 1);
    check("rst_rden", 32'(bif.o_efuse_rden), 0);
    check("rst_addr", 32'(bif.o_efuse_addr), 0);
    check("rst_wr_en", 32'(bif.o_efuse_wr_en), 0);
    check("rst_wr_addr", 32'(bif.o_efuse_wr_addr), 0);
    check("rst_wr_data", 32'(bif.o_efuse_wr_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_load($sformatf("vec%0d", i), tbl[i].w,
               tbl[i].vld, tbl[i].crc, 1'b0);

    // Power loss during the read strobe of word 3
    for (int i = 0; i < 8; i++) mem[i] = tbl[0].w[8*i +: 8];
    @(negedge clk);
    mon_on = 1'b0;
    wq.delete();
    bif.i_efuse_load_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bif.o_efuse_rden && bif.o_efuse_addr == 3'd3)
        found = 1'b1;
    end
    check("abort_reach", 32'(found), 1);
    bif.i_pwr_on = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bif.o_efuse_busy), 0);
    check("abort_csb", 32'(bif.o_efuse_csb), 1);
    check("abort_rden", 32'(bif.o_efuse_rden), 0);
    check("abort_wr_en", 32'(bif.o_efuse_wr_en), 0);
    check("abort_vld", 32'(bif.o_efuse_vld), 0);
    cnt_done = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (bif.o_efuse_load_done) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);
    check("abort_wr_cnt", wq.size(), 3);
    check("abort_crc", 32'(bif.o_efuse_crc_err), 0);
    bif.i_pwr_on = 1'b1;
    bif.i_efuse_load_req = 1'b0;
    @(negedge clk);
    run_load("after_abort", tbl[0].w, 1'b1, 1'b0, 1'b0);

    // Request held high after done must not restart
    run_load("held", tbl[0].w, 1'b1, 1'b0, 1'b1);
    cnt_done = 0;
    cnt_busy = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bif.o_efuse_load_done) cnt_done++;
      if (bif.o_efuse_busy) cnt_busy++;
    end
    check("held_no_done", cnt_done, 0);
    check("held_no_busy", cnt_busy, 0);
    bif.i_efuse_load_req = 1'b0;
    run_load("re_req", tbl[1].w, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    bif.i_efuse_load_req = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_busy", 32'(bif.o_efuse_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bif.o_efuse_busy), 0);
    check("arst_csb", 32'(bif.o_efuse_csb), 1);
    check("arst_rden", 32'(bif.o_efuse_rden), 0);
    check("arst_addr", 32'(bif.o_efuse_addr), 0);
    check("arst_wr_data", 32'(bif.o_efuse_wr_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_from_reset", 32'(bif.o_efuse_busy), 1);
    bif.i_efuse_load_req = 1'b0;
    @(negedge clk);
    check("req_fall_busy", 32'(bif.o_efuse_busy), 0);
    check("req_fall_csb", 32'(bif.o_efuse_csb), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lv_efuse_load_ctrl.md
Name: lv_efuse_load_ctrl

Overview:
Efuse load sequencer that serves the efuse load request issued by the LV control FSM while it is in WAIT_ST. It reads EFUSE_WORD_NUM words from the analog efuse macro using timed setup, read-pulse and hold phases. Each word is written into the shadow register file, and the trailing checksum word is verified. The block returns a one-cycle load-done pulse and a level efuse-valid flag; these feed the FSM's efuse_load_done and reg_efuse_vld inputs.

Parameters:
EFUSE_WORD_NUM, 8, words read per load, including the checksum word at the last address; legal range 2..2^EFUSE_ADDR_W
EFUSE_ADDR_W, 3, efuse and shadow address width
EFUSE_DATA_W, 8, efuse word width
RD_SETUP_CYC, 4, cycles with address stable and csb low before the read strobe; minimum 1
RD_PULSE_CYC, 8, cycles the read strobe is high; minimum 1
RD_HOLD_CYC, 2, cycles after the strobe before the address may change; minimum 1
CYC_CNT_W, 4, phase counter width; must hold the largest *_CYC value

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_pwr_on  in  1  power good; low aborts any load
i_efuse_load_req  in  1  level request from the control FSM; held until done
o_efuse_load_done  out  1  one-cycle pulse when a load completes
o_efuse_vld  out  1  last completed load passed the checksum and was not blank
o_efuse_crc_err  out  1  last completed load failed the checksum
o_efuse_busy  out  1  high in any state other than IDLE
o_efuse_csb  out  1  efuse macro chip select, active low
o_efuse_rden  out  1  efuse macro read strobe
o_efuse_addr  out  EFUSE_ADDR_W  efuse macro address
i_efuse_rdata  in  EFUSE_DATA_W  efuse macro read data, valid during the strobe
o_efuse_wr_en  out  1  shadow register write pulse
o_efuse_wr_addr  out  EFUSE_ADDR_W  shadow register address
o_efuse_wr_data  out  EFUSE_DATA_W  shadow register data

Behaviour:
- Reset values: done=0, vld=0, crc_err=0, busy=0, csb=1, rden=0, addr=0, wr_en=0, wr_addr=0, wr_data=0. FSM resets to IDLE and req_d resets to 0.
- A load starts only on a rising edge of the request (req & ~req_d) with i_pwr_on=1. A request already high out of reset counts as an edge. A request held high after done does not restart a load.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK, DONE. All outputs are registered.
- IDLE -> SETUP on a start edge. At the same edge: vld and crc_err clear, the word counter and checksum accumulator clear, addr=0, csb=0.
- SETUP: lasts RD_SETUP_CYC cycles, then goes to PULSE. rden=1 throughout PULSE.
- PULSE: lasts RD_PULSE_CYC cycles. i_efuse_rdata is sampled on the last PULSE cycle. Then go to HOLD with rden=0.
- HOLD: on its first cycle, wr_en=1 for exactly one cycle, wr_addr=current word index, wr_data=sampled word. The checksum accumulator XORs in the word and an OR-reduction flag tracks non-zero data words. HOLD lasts RD_HOLD_CYC cycles.
- At the end of HOLD: if the word index is less than EFUSE_WORD_NUM-1, increment the index and addr, then go to SETUP; csb stays 0. Otherwise go to CHECK with csb=1. The index never wraps.
- CHECK: one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE. In the same cycle, vld=1 only if the XOR of all words is 0 and at least one data word (indices 0..N-2) is non-zero. crc_err=1 if the XOR is non-zero. An all-zero (blank) array gives vld=0 and crc_err=0.
- Latency with defaults: start edge sampled at cycle 0. Each word takes 14 cycles, so the last HOLD ends at cycle 112, CHECK is cycle 113, and done pulses at cycle 114.
- Abort: i_pwr_on=0 or the request falling in any non-IDLE state forces IDLE on the next edge. On abort, csb=1, rden=0, wr_en=0, no done pulse, and vld/crc_err stay 0. Shadow words already written are not rolled back.
- If an abort and the last HOLD cycle coincide, abort wins.
- Asynchronous reset mid-load returns all outputs immediately to their reset values.

Test Plan:
- Words 0x11,0x22,0x33,0x44,0x55,0x66,0x77 plus checksum 0x00 (the XOR of all eight words is 0x00). Request rises at cycle 0 -> 8 wr_en pulses at addresses 0..7 with matching data; done at cycle 114; vld=1; crc_err=0; busy low at cycle 115.
- Same data with the checksum word changed to 0x01 -> done at cycle 114, vld=0, crc_err=1.
- Blank array, all words 0x00 -> done at cycle 114, vld=0, crc_err=0.
- Strobe timing check -> for every word, csb low ≥4 cycles before rden rises, rden high for exactly 8 cycles, addr stable until 2 cycles after rden falls.
- i_pwr_on drops during the PULSE of word 3 -> IDLE on the next edge, csb=1, rden=0, no done pulse, vld=0. After pwr_on recovers, a new request edge runs a full load with done at +114.
- Request held high for 50 cycles after done -> no second load, busy stays 0. Then drop the request for 1 cycle and raise it again -> a new load starts.
